// File: rtl/vlsu_cam_mp.sv
`default_nettype none
// ============================================================================
//  Module   : vlsu_cam_mp
//  Brief    : Multi-port CAM for the VLSU load/store queue. WRITE write
//             ports fill entries, READ search ports return the oldest hit in
//             ring order from head_i. Per-entry valid bits, a clear port and
//             a live occupancy count. Search results are registered (1 cycle).
//  Options  : CAM_WRITE_BYPASS_EN - searches also see this cycle's writes
//             (and clears) instead of only the registered array state.
//  Revision : 1.0 - initial release
// ============================================================================
module vlsu_cam_mp #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 32,
    parameter int WRITE = 2,
    parameter int READ  = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(DEPTH)-1:0]          head_i,
    input  logic [READ*DEPTH-1:0]             enable_i,
    input  logic [WRITE-1:0]                  write_i,
    input  logic [WRITE*$clog2(DEPTH)-1:0]    write_addr_i,
    input  logic [WRITE*WIDTH-1:0]            write_data_i,
    input  logic                              clear_i,
    input  logic [$clog2(DEPTH)-1:0]          clear_addr_i,
    input  logic [READ-1:0]                   read_i,
    input  logic [READ*WIDTH-1:0]             read_data_i,
    output logic [READ-1:0]                   match_o,
    output logic [READ*$clog2(DEPTH)-1:0]     match_data_o,
    output logic [$clog2(DEPTH):0]            count_o
);

    localparam int ADDRESS = $clog2(DEPTH);

    // Storage and registered outputs
    logic [WIDTH-1:0]          r_data [DEPTH];
    logic [DEPTH-1:0]          r_valid;
    logic [READ-1:0]           r_match;
    logic [READ*ADDRESS-1:0]   r_match_data;
    logic [ADDRESS:0]          r_count;

    // Per-entry write decode, next valid state and the view searches see
    logic [DEPTH-1:0]          w_wr_hit;
    logic [WIDTH-1:0]          w_wr_data [DEPTH];
    logic [DEPTH-1:0]          w_valid_next;
    logic [ADDRESS:0]          w_count_next;
    logic [DEPTH-1:0]          w_view_valid;
    logic [WIDTH-1:0]          w_view_data [DEPTH];
    logic [DEPTH-1:0]          w_cand [READ];
    logic [READ-1:0]           w_hit;
    logic [ADDRESS-1:0]        w_hit_idx [READ];

    // Write decode: ports scanned ascending so the highest colliding port wins
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_wr_hit[k]  = 1'b0;
            w_wr_data[k] = r_data[k];
            for (int p = 0; p < WRITE; p++) begin
                if (write_i[p] && write_addr_i[p*ADDRESS +: ADDRESS] == ADDRESS'(k)) begin
                    w_wr_hit[k]  = 1'b1;
                    w_wr_data[k] = write_data_i[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next valid vector: a write beats a same-cycle clear; count is its popcount
    always_comb begin
        w_count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_wr_hit[k])
                w_valid_next[k] = 1'b1;
            else if (clear_i && clear_addr_i == ADDRESS'(k))
                w_valid_next[k] = 1'b0;
            else
                w_valid_next[k] = r_valid[k];
            w_count_next = w_count_next + (ADDRESS+1)'(w_valid_next[k]);
        end
    end

`ifdef CAM_WRITE_BYPASS_EN
    // Searches see the post-write/post-clear state of this cycle
    assign w_view_valid = w_valid_next;
    assign w_view_data  = w_wr_data;
`else
    // Searches see only the registered array; writes become visible next cycle
    assign w_view_valid = r_valid;
    assign w_view_data  = r_data;
`endif

    // Candidate vector per search port
    for (genvar r = 0; r < READ; r++) begin : g_port
        for (genvar k = 0; k < DEPTH; k++) begin : g_entry
            assign w_cand[r][k] = w_view_valid[k] & enable_i[r*DEPTH + k]
                                & (w_view_data[k] == read_data_i[r*WIDTH +: WIDTH]);
        end
    end

    // Ring priority: scan offsets high to low so the smallest offset from head_i lands last
    always_comb begin
        for (int r = 0; r < READ; r++) begin
            w_hit[r]     = 1'b0;
            w_hit_idx[r] = '0;
            for (int i = DEPTH-1; i >= 0; i--) begin
                if (w_cand[r][head_i + ADDRESS'(i)]) begin
                    w_hit[r]     = 1'b1;
                    w_hit_idx[r] = head_i + ADDRESS'(i);
                end
            end
        end
    end

    // Data array: written by the winning port, intentionally not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst_n && w_wr_hit[k])
                r_data[k] <= w_wr_data[k];
        end
    end

    // Valid bits, occupancy count and registered search results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_count      <= '0;
            r_match      <= '0;
            r_match_data <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            for (int r = 0; r < READ; r++) begin
                r_match[r] <= read_i[r] & w_hit[r];
                if (read_i[r])
                    r_match_data[r*ADDRESS +: ADDRESS] <= w_hit_idx[r];
            end
        end
    end

    assign match_o      = r_match;
    assign match_data_o = r_match_data;
    assign count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_vlsu_cam_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vlsu_cam_mp
//  Brief    : Directed self-checking bench for vlsu_cam_mp.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vlsu_cam_mp;

    localparam int W  = 50;
    localparam int D  = 32;
    localparam int NW = 2;
    localparam int NR = 3;
    localparam int A  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [A-1:0]      head_i;
    logic [NR*D-1:0]   enable_i;
    logic [NW-1:0]     write_i;
    logic [NW*A-1:0]   write_addr_i;
    logic [NW*W-1:0]   write_data_i;
    logic              clear_i;
    logic [A-1:0]      clear_addr_i;
    logic [NR-1:0]     read_i;
    logic [NR*W-1:0]   read_data_i;
    logic [NR-1:0]     match_o;
    logic [NR*A-1:0]   match_data_o;
    logic [A:0]        count_o;

    int checks = 0;
    int errors = 0;

    vlsu_cam_mp #(.WIDTH(W), .DEPTH(D), .WRITE(NW), .READ(NR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .head_i       (head_i),
        .enable_i     (enable_i),
        .write_i      (write_i),
        .write_addr_i (write_addr_i),
        .write_data_i (write_data_i),
        .clear_i      (clear_i),
        .clear_addr_i (clear_addr_i),
        .read_i       (read_i),
        .read_data_i  (read_data_i),
        .match_o      (match_o),
        .match_data_o (match_data_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle outputs 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_i = '0;
        clear_i = 1'b0;
        read_i  = '0;
    endtask

    task automatic wr(input int p, input int addr, input logic [W-1:0] data);
        write_i[p] = 1'b1;
        write_addr_i[p*A +: A] = A'(addr);
        write_data_i[p*W +: W] = data;
    endtask

    task automatic rd(input int r, input logic [W-1:0] key);
        read_i[r] = 1'b1;
        read_data_i[r*W +: W] = key;
    endtask

    function automatic logic [A-1:0] idx(input int r);
        return match_data_o[r*A +: A];
    endfunction

    initial begin
        rst_n        = 1'b0;
        head_i       = '0;
        enable_i     = '1;
        write_addr_i = '0;
        write_data_i = '0;
        clear_addr_i = '0;
        read_data_i  = '0;
        idle();

        // 1. Reset held 3 cycles
        repeat (3) step();
        chk("rst_match", 64'(match_o), 64'h0);
        chk("rst_mdata", 64'(match_data_o), 64'h0);
        chk("rst_count", 64'(count_o), 64'h0);
        rst_n = 1'b1;
        rd(0, '0); rd(1, '0); rd(2, '0);
        step();
        chk("empty_search", 64'(match_o), 64'h0);
        chk("empty_mdata", 64'(match_data_o), 64'h0);
        idle();

        // 2. Fill all entries with j+1 through port 0
        for (int j = 0; j < D; j++) begin
            wr(0, j, W'(j + 1));
            step();
            if (j == 0) chk("count_first", 64'(count_o), 64'd1);
        end
        idle();
        chk("count_full", 64'(count_o), 64'd32);
        rd(2, W'(17));
        step();
        chk("fill_match", 64'(match_o), 64'b100);
        chk("fill_idx", 64'(idx(2)), 64'd16);
        idle();

        // 3. Duplicate 0x55 at entries 3 and 28; ring priority
        wr(0, 3, W'(85)); wr(1, 28, W'(85));
        step();
        idle();
        chk("count_rewrite", 64'(count_o), 64'd32);
        head_i = 5'd20; rd(0, W'(85)); step();
        chk("ring_h20", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd28}));
        head_i = 5'd2; step();
        chk("ring_h2", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd3}));
        head_i = 5'd29; step();
        chk("ring_h29_wrap", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd3}));
        head_i = 5'd28; step();
        chk("ring_h28", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd28}));
        idle(); step();
        chk("noread_match", 64'(match_o[0]), 64'h0);
        chk("noread_hold", 64'(idx(0)), 64'd28);
        head_i = '0;

        // 4. Free entries 9 (holds 0xA) and 5, then collide both ports on 5
        clear_i = 1'b1; clear_addr_i = 5'd9; step();
        clear_addr_i = 5'd5; step();
        idle();
        chk("count_two_clears", 64'(count_o), 64'd30);
        wr(0, 5, W'('hA)); wr(1, 5, W'('hB)); step();
        idle();
        chk("collide_count", 64'(count_o), 64'd31);
        rd(0, W'('hA)); rd(1, W'('hB)); step();
        chk("collide_match", 64'(match_o), 64'b010);
        chk("collide_idx", 64'({idx(1), idx(0)}), 64'({5'd5, 5'd0}));
        idle();

        // 5. Clear + write same entry: write wins; then clear alone
        clear_i = 1'b1; clear_addr_i = 5'd7; wr(0, 7, W'('h9)); step();
        idle();
        chk("clrwr_count", 64'(count_o), 64'd31);
        rd(0, W'('h9)); step();
        chk("clrwr_hit", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd7}));
        idle();
        clear_i = 1'b1; clear_addr_i = 5'd7; step();
        idle();
        chk("clr_count", 64'(count_o), 64'd30);
        rd(0, W'('h9)); step();
        chk("clr_miss7_hit8", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd8}));
        idle();

        // 6. Write and search the same entry in the same cycle
        wr(0, 9, W'('h33)); rd(0, W'('h33)); step();
        idle();
`ifdef CAM_WRITE_BYPASS_EN
        chk("bypass_same_cycle", 64'({match_o[0], idx(0)}), 64'({1'b1, 5'd9}));
`else
        chk("bypass_same_cycle", 64'({match_o[0], idx(0)}), 64'({1'b0, 5'd0}));
`endif
        chk("bypass_count", 64'(count_o), 64'd31);

        // Enable mask on the only matching entry
        enable_i[1*D + 9] = 1'b0;
        rd(1, W'('h33)); rd(2, W'('h33)); step();
        chk("enable_mask", 64'(match_o[2:1]), 64'b10);
        chk("enable_idx2", 64'(idx(2)), 64'd9);
        enable_i = '1;

        // Reset asserted while searches are in flight
        rd(0, W'('h33)); rd(1, W'(17)); rd(2, W'(85));
        rst_n = 1'b0; step();
        chk("midrst_match", 64'(match_o), 64'h0);
        chk("midrst_mdata", 64'(match_data_o), 64'h0);
        chk("midrst_count", 64'(count_o), 64'h0);
        rst_n = 1'b1; step();
        chk("post_rst_search", 64'(match_o), 64'h0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
